// File: rtl/ex_stage_buf.sv
// Execute-stage output buffer: 2-entry skid FIFO of ALU results with
// single-cycle branch-redirect resolution on accept.
module ex_stage_buf #(
  parameter int unsigned DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [31:0] result_i,
  input  logic        flag_i,
  input  logic [4:0]  rd_i,
  input  logic        wb_en_i,
  input  logic        br_en_i,
  input  logic        br_inv_i,
  input  logic [31:0] br_target_i,
  input  logic        flush_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] out_result_o,
  output logic [4:0]  out_rd_o,
  output logic        out_wb_en_o,
  output logic        redirect_o,
  output logic [31:0] redirect_pc_o
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned RW   = 5;

  if (DEPTH != 2) begin : g_depth_check
    $error("ex_stage_buf supports DEPTH=2 only");
  end

  typedef struct packed {
    logic [XLEN-1:0] result;
    logic [RW-1:0]   rd;
    logic            wb_en;
  } entry_t;

  typedef enum logic [1:0] {S_EMPTY, S_ONE, S_FULL} state_e;

  state_e          state_q, state_d;
  entry_t          head_q, head_d, tail_q, tail_d;
  logic            in_ready_q, in_ready_d;
  logic            out_valid_q, out_valid_d;
  logic            redirect_q, redirect_d;
  logic [XLEN-1:0] pc_q, pc_d;

  logic   accept, pop, taken;
  entry_t in_entry;

  // Next-state, payload movement and branch resolution
  always_comb begin
    state_d    = state_q;
    head_d     = head_q;
    tail_d     = tail_q;
    redirect_d = 1'b0;
    pc_d       = pc_q;

    accept   = in_valid_i & in_ready_q;
    pop      = out_valid_q & out_ready_i;
    taken    = accept & br_en_i & (flag_i ^ br_inv_i);
    // wb_en is masked at write time so the output stays a plain register
    in_entry = '{result: result_i, rd: rd_i, wb_en: wb_en_i & (rd_i != RW'(0))};

    unique case (state_q)
      S_EMPTY: begin
        if (accept) begin
          state_d = S_ONE;
          head_d  = in_entry;
        end
      end
      S_ONE: begin
        if (accept && pop) begin
          head_d = in_entry;
        end else if (accept) begin
          state_d = S_FULL;
          tail_d  = in_entry;
        end else if (pop) begin
          state_d = S_EMPTY;
        end
      end
      S_FULL: begin
        if (pop) begin
          state_d = S_ONE;
          head_d  = tail_q;
        end
      end
      default: state_d = S_EMPTY;
    endcase

    if (taken) begin
      redirect_d = 1'b1;
      pc_d       = br_target_i;
    end

    if (flush_i) begin
      state_d    = S_EMPTY;
      redirect_d = 1'b0;
      pc_d       = pc_q;
    end

    in_ready_d  = (state_d != S_FULL);
    out_valid_d = (state_d != S_EMPTY);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= S_EMPTY;
      head_q      <= '0;
      tail_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      redirect_q  <= 1'b0;
      pc_q        <= '0;
    end else begin
      state_q     <= state_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      redirect_q  <= redirect_d;
      pc_q        <= pc_d;
    end
  end

  assign in_ready_o    = in_ready_q;
  assign out_valid_o   = out_valid_q;
  assign out_result_o  = head_q.result;
  assign out_rd_o      = head_q.rd;
  assign out_wb_en_o   = head_q.wb_en;
  assign redirect_o    = redirect_q;
  assign redirect_pc_o = pc_q;

endmodule

// File: tb/tb_ex_stage_buf.sv
// Scoreboard bench for ex_stage_buf: directed scenarios then random traffic,
// checked against an in-order queue model of the buffer contents.
module tb_ex_stage_buf;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] result;
  logic        flag;
  logic [4:0]  rd;
  logic        wb_en;
  logic        br_en;
  logic        br_inv;
  logic [31:0] br_target;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [4:0]  out_rd;
  logic        out_wb_en;
  logic        redirect;
  logic [31:0] redirect_pc;

  ex_stage_buf #(.DEPTH(2)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .in_valid_i   (in_valid),
    .in_ready_o   (in_ready),
    .result_i     (result),
    .flag_i       (flag),
    .rd_i         (rd),
    .wb_en_i      (wb_en),
    .br_en_i      (br_en),
    .br_inv_i     (br_inv),
    .br_target_i  (br_target),
    .flush_i      (flush),
    .out_valid_o  (out_valid),
    .out_ready_i  (out_ready),
    .out_result_o (out_result),
    .out_rd_o     (out_rd),
    .out_wb_en_o  (out_wb_en),
    .redirect_o   (redirect),
    .redirect_pc_o(redirect_pc)
  );

  typedef struct packed {
    logic [31:0] res;
    logic [4:0]  rd;
    logic        wb;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic        acc_now = 1'b0;
  logic        acc_taken = 1'b0;
  logic [31:0] acc_pc = '0;
  logic        exp_redir = 1'b0;
  logic [31:0] exp_pc = '0;
  logic [31:0] last_pc = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual 0x%08h required 0x%08h at %0t", name, act, req, $time);
    end
  endtask

  // One cycle of stimulus; the expected entry is queued when the accept will happen
  task automatic drive(input logic v, input logic [31:0] r, input logic [4:0] d,
                       input logic w, input logic be, input logic bi, input logic f,
                       input logic [31:0] tgt, input logic fl, input logic ordy);
    @(posedge clk);
    #1;
    in_valid  = v;   result = r;   rd = d;     wb_en = w;
    br_en     = be;  br_inv = bi;  flag = f;   br_target = tgt;
    flush     = fl;  out_ready = ordy;
    acc_now   = v & in_ready & ~fl;
    acc_taken = acc_now & be & (f ^ bi);
    acc_pc    = tgt;
    if (acc_now) sb.push_back('{res: r, rd: d, wb: w & (d != 5'd0)});
  endtask

  task automatic idle(input logic ordy);
    drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, ordy);
  endtask

  task automatic do_reset(input int n);
    @(posedge clk);
    #1;
    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0;
    acc_now = 1'b0; acc_taken = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_redirect", 32'(redirect), 32'd0);
    chk("rst_redirect_pc", redirect_pc, 32'd0);
    chk("rst_out_result", out_result, 32'd0);
    chk("rst_out_rd", 32'(out_rd), 32'd0);
    chk("rst_out_wb_en", 32'(out_wb_en), 32'd0);
  endtask

  // Monitor: occupancy, handshake flags, popped payload and redirect pulses
  always @(negedge clk) begin
    int   occ;
    exp_t e;
    if (!rst_n) begin
      sb.delete();
      exp_redir = 1'b0;
      last_pc   = '0;
    end else begin
      occ = sb.size() - int'(acc_now);
      chk("out_valid", 32'(out_valid), 32'(occ > 0));
      chk("in_ready", 32'(in_ready), 32'(occ < 2));
      chk("redirect", 32'(redirect), 32'(exp_redir));
      chk("redirect_pc", redirect_pc, exp_redir ? exp_pc : last_pc);
      if (exp_redir) last_pc = exp_pc;
      if (out_valid && out_ready) begin
        if (occ == 0) begin
          chk("pop_when_empty", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("out_result", out_result, e.res);
          chk("out_rd", 32'(out_rd), 32'(e.rd));
          chk("out_wb_en", 32'(out_wb_en), 32'(e.wb));
        end
      end
      if (flush) sb.delete();
      exp_redir = acc_taken;
      exp_pc    = acc_pc;
    end
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; result = '0; flag = 1'b0; rd = '0;
    wb_en = 1'b0; br_en = 1'b0; br_inv = 1'b0; br_target = '0;
    flush = 1'b0; out_ready = 1'b0;
    do_reset(3);

    // Single pass
    drive(1'b1, 32'h0000_00AA, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    idle(1'b1); idle(1'b1);

    // Backpressure fill then drain in order
    drive(1'b1, 32'h11, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    drive(1'b1, 32'h22, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    drive(1'b1, 32'h33, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    idle(1'b0);
    idle(1'b1); idle(1'b1); idle(1'b1);

    // Branch taken, then inverted (not taken)
    drive(1'b1, 32'h5, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0100, 1'b0, 1'b1);
    idle(1'b1); idle(1'b1);
    drive(1'b1, 32'h6, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0200, 1'b0, 1'b1);
    idle(1'b1); idle(1'b1);

    // Flush in FULL with a taken branch presented
    drive(1'b1, 32'h44, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    drive(1'b1, 32'h55, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    drive(1'b1, 32'h66, 5'd6, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0300, 1'b1, 1'b0);
    idle(1'b1); idle(1'b1);

    // Flush in ONE with an acceptable taken branch: accept and redirect suppressed
    drive(1'b1, 32'h77, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    drive(1'b1, 32'h88, 5'd8, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0400, 1'b1, 1'b1);
    idle(1'b1); idle(1'b1);

    // Redirect pulse completes across a flush
    drive(1'b1, 32'h99, 5'd9, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0500, 1'b0, 1'b1);
    drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    idle(1'b1); idle(1'b1);

    // Zero register suppresses write-back
    drive(1'b1, 32'hABCD, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    idle(1'b1); idle(1'b1);

    // Mid-operation reset from FULL, then one accept lands in ONE
    drive(1'b1, 32'hA1, 5'd10, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    drive(1'b1, 32'hA2, 5'd11, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0600, 1'b0, 1'b0);
    do_reset(1);
    drive(1'b1, 32'hB1, 5'd12, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    idle(1'b0);
    idle(1'b1); idle(1'b1);

    // Random traffic
    for (int i = 0; i < 2000; i++) begin
      drive(1'($urandom_range(0, 3) != 0), $urandom, 5'($urandom_range(0, 31)),
            1'($urandom), 1'($urandom_range(0, 2) == 0), 1'($urandom), 1'($urandom),
            $urandom, 1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 2) != 0));
    end
    idle(1'b1); idle(1'b1); idle(1'b1);
    @(negedge clk);
    chk("drained", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
